sda_kernel_perf_counter: RTL and testbench

Kernel run-time performance monitor on the wrapper's register bus, alongside the kernel control register. It observes the action block's go/done request lines, measures each run in `ap_clk` cycles, and accumulates run statistics. Software reads the statistics through the same request/acknowledge register interface that the AXI slave register selector drives.

---
 rtl/sda_kernel_perf_counter_if.sv | 16 +
 rtl/sda_kernel_perf_counter.sv | 179 +++++++++++++++++
 tb/tb_sda_kernel_perf_counter.sv | 220 ++++++++++++++++++++++
 3 files changed

// File: rtl/sda_kernel_perf_counter_if.sv
// Request/acknowledge register bus between the wrapper's register selector and
// the kernel performance counter.
interface sda_kernel_perf_counter_if;
  logic        reg_req;
  logic        reg_ack;
  logic        reg_write_en;
  logic [5:0]  reg_addr;
  logic [31:0] reg_wdata;
  logic [3:0]  reg_wstrb;
  logic [31:0] reg_rdata;

  modport master (output reg_req, reg_write_en, reg_addr, reg_wdata, reg_wstrb,
                  input  reg_ack, reg_rdata);
  modport slave  (input  reg_req, reg_write_en, reg_addr, reg_wdata, reg_wstrb,
                  output reg_ack, reg_rdata);
endinterface

// File: rtl/sda_kernel_perf_counter.sv
// Kernel run-time monitor: times go->done runs in ap_clk cycles and keeps run statistics.
// Optional MAX tracking is enabled by defining SDA_KERNEL_PERF_MAX_EN.
module sda_kernel_perf_counter #(
  parameter int CNT_WIDTH = 48
) (
  input  logic                      ap_clk,
  input  logic                      ap_rst_n,
  sda_kernel_perf_counter_if.slave  bus,
  input  logic                      go_0r,
  input  logic                      done_0r,
  output logic                      perf_running
);
  typedef enum logic {IDLE, RUN} state_e;

  state_e                 state_q, state_d;
  logic                   armed_q, ack_q, wr_pend_q, ws0_q, en_q, ovf_q;
  logic [3:0]             wa_q;
  logic [1:0]             wd_q;
  logic [31:0]            rdata_q, rd_mux, run_cnt_q;
  logic                   go_q, done_q;
  logic [CNT_WIDTH-1:0]   cur_q, last_q, total_q;
  logic [CNT_WIDTH:0]     tot_sum;
  logic [31:0]            last_sh_q, total_sh_q;
  logic                   accept, rd_acc, ctrl_wr, clr, abort;
  logic                   go_rise, done_rise, enter_run, done_upd;
  logic                   unused_bits;
`ifdef SDA_KERNEL_PERF_MAX_EN
  logic [CNT_WIDTH-1:0]   max_q;
  logic [31:0]            max_sh_q;
`endif

  function automatic logic [31:0] hi32(input logic [CNT_WIDTH-1:0] x);
    logic [63:0] w;
    w = 64'(x);
    return w[63:32];
  endfunction

  assign accept      = bus.reg_req && armed_q;
  assign rd_acc      = accept && !bus.reg_write_en;
  // Writes land one cycle after acceptance, in the ack cycle.
  assign ctrl_wr     = wr_pend_q && (wa_q == 4'd0) && ws0_q;
  assign clr         = ctrl_wr && wd_q[1];
  assign abort       = ctrl_wr && !wd_q[0];
  assign go_rise     = go_0r && !go_q;
  assign done_rise   = done_0r && !done_q;
  assign tot_sum     = {1'b0, total_q} + {1'b0, cur_q};
  assign perf_running = (state_q == RUN);
  assign bus.reg_ack   = ack_q;
  assign bus.reg_rdata = rdata_q;
  assign unused_bits = ^{bus.reg_addr[1:0], bus.reg_wdata[31:2], bus.reg_wstrb[3:1]};

  always_comb begin
    state_d  = state_q;
    done_upd = 1'b0;
    case (state_q)
      IDLE: if (go_rise && en_q && !abort) state_d = RUN;
      RUN: begin
        if (abort) state_d = IDLE;
        else if (done_rise) begin
          state_d  = IDLE;
          done_upd = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
    if (clr) begin
      state_d  = IDLE;
      done_upd = 1'b0;
    end
  end

  assign enter_run = (state_q == IDLE) && (state_d == RUN);

  always_comb begin
    rd_mux = '0;
    case (bus.reg_addr[5:2])
      4'd0: rd_mux = {28'd0, ovf_q, perf_running, 1'b0, en_q};
      4'd1: rd_mux = run_cnt_q;
      4'd2: rd_mux = last_q[31:0];
      4'd3: rd_mux = last_sh_q;
      4'd4: rd_mux = total_q[31:0];
      4'd5: rd_mux = total_sh_q;
`ifdef SDA_KERNEL_PERF_MAX_EN
      4'd6: rd_mux = max_q[31:0];
      4'd7: rd_mux = max_sh_q;
`endif
      default: rd_mux = '0;
    endcase
  end

  always_ff @(posedge ap_clk or negedge ap_rst_n) begin
    if (!ap_rst_n) begin
      armed_q   <= 1'b1;
      ack_q     <= 1'b0;
      rdata_q   <= '0;
      wr_pend_q <= 1'b0;
      wa_q      <= '0;
      wd_q      <= '0;
      ws0_q     <= 1'b0;
      go_q      <= 1'b0;
      done_q    <= 1'b0;
      state_q   <= IDLE;
      en_q      <= 1'b0;
    end else begin
      ack_q     <= accept;
      rdata_q   <= rd_acc ? rd_mux : '0;
      wr_pend_q <= accept && bus.reg_write_en;
      wa_q      <= bus.reg_addr[5:2];
      wd_q      <= bus.reg_wdata[1:0];
      ws0_q     <= bus.reg_wstrb[0];
      // One ack per request: re-arm only once req has been seen low.
      if (accept)            armed_q <= 1'b0;
      else if (!bus.reg_req) armed_q <= 1'b1;
      go_q      <= go_0r;
      done_q    <= done_0r;
      state_q   <= state_d;
      if (ctrl_wr) en_q <= wd_q[0];
    end
  end

  always_ff @(posedge ap_clk or negedge ap_rst_n) begin
    if (!ap_rst_n) begin
      cur_q      <= '0;
      last_q     <= '0;
      total_q    <= '0;
      run_cnt_q  <= '0;
      ovf_q      <= 1'b0;
      last_sh_q  <= '0;
      total_sh_q <= '0;
`ifdef SDA_KERNEL_PERF_MAX_EN
      max_q      <= '0;
      max_sh_q   <= '0;
`endif
    end else if (clr) begin
      cur_q      <= '0;
      last_q     <= '0;
      total_q    <= '0;
      run_cnt_q  <= '0;
      ovf_q      <= 1'b0;
      last_sh_q  <= '0;
      total_sh_q <= '0;
`ifdef SDA_KERNEL_PERF_MAX_EN
      max_q      <= '0;
      max_sh_q   <= '0;
`endif
    end else begin
      if (enter_run) cur_q <= CNT_WIDTH'(1);
      else if (state_q == RUN) begin
        if (&cur_q) ovf_q <= 1'b1;
        else        cur_q <= cur_q + 1'b1;
      end
      if (done_upd) begin
        last_q <= cur_q;
        if (tot_sum[CNT_WIDTH]) begin
          total_q <= '1;
          ovf_q   <= 1'b1;
        end else begin
          total_q <= tot_sum[CNT_WIDTH-1:0];
        end
        if (&run_cnt_q) ovf_q <= 1'b1;
        else            run_cnt_q <= run_cnt_q + 1'b1;
`ifdef SDA_KERNEL_PERF_MAX_EN
        if (cur_q > max_q) max_q <= cur_q;
`endif
      end
      // LO reads snapshot the matching HI half so a LO/HI pair is coherent.
      if (rd_acc) begin
        case (bus.reg_addr[5:2])
          4'd2: last_sh_q  <= hi32(last_q);
          4'd4: total_sh_q <= hi32(total_q);
`ifdef SDA_KERNEL_PERF_MAX_EN
          4'd6: max_sh_q   <= hi32(max_q);
`endif
          default: ;
        endcase
      end
    end
  end
endmodule

// File: tb/tb_sda_kernel_perf_counter.sv
// Scoreboard bench for sda_kernel_perf_counter: driver queues expected read data,
// a negedge monitor pops and compares on every reg_ack.
module tb_sda_kernel_perf_counter;
  localparam int CW = 48;

  logic ap_clk = 1'b0;
  logic ap_rst_n = 1'b0;
  logic go_0r = 1'b0;
  logic done_0r = 1'b0;
  logic perf_running;

  sda_kernel_perf_counter_if bus();

  sda_kernel_perf_counter #(.CNT_WIDTH(CW)) dut (
    .ap_clk       (ap_clk),
    .ap_rst_n     (ap_rst_n),
    .bus          (bus),
    .go_0r        (go_0r),
    .done_0r      (done_0r),
    .perf_running (perf_running)
  );

  always #5 ap_clk = ~ap_clk;

  int          n_chk = 0;
  int          n_fail = 0;
  int          run_cyc = 0;
  logic [31:0] exp_q[$];
  string       name_q[$];

`ifdef SDA_KERNEL_PERF_MAX_EN
  localparam logic [31:0] MAX_EXP = 32'd100;
`else
  localparam logic [31:0] MAX_EXP = 32'd0;
`endif

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
    end
  endtask

  // Monitor: every ack consumes one expectation; rdata must be 0 outside acks.
  always @(negedge ap_clk) begin
    if (bus.reg_ack === 1'b1) begin
      if (exp_q.size() == 0) begin
        n_chk++;
        n_fail++;
        $display("FAIL unexpected_ack: got ack with rdata 0x%0h, expected no ack", bus.reg_rdata);
      end else begin
        chk(name_q.pop_front(), {32'd0, bus.reg_rdata}, {32'd0, exp_q.pop_front()});
      end
    end else if (bus.reg_rdata !== 32'd0) begin
      chk("rdata_idle", {32'd0, bus.reg_rdata}, 64'd0);
    end
  end

  always @(negedge ap_clk) if (perf_running === 1'b1) run_cyc++;

  task automatic reg_acc(input logic we, input logic [5:0] a, input logic [31:0] d,
                         input logic [3:0] s, input logic [31:0] e, input string nm);
    int k;
    exp_q.push_back(e);
    name_q.push_back(nm);
    @(posedge ap_clk); #1;
    bus.reg_req = 1'b1; bus.reg_write_en = we; bus.reg_addr = a;
    bus.reg_wdata = d; bus.reg_wstrb = s;
    @(negedge ap_clk);
    chk({nm, "_early_ack"}, {63'd0, bus.reg_ack}, 64'd0);
    k = 0;
    @(negedge ap_clk);
    while (bus.reg_ack !== 1'b1 && k < 8) begin
      k++;
      @(negedge ap_clk);
    end
    chk({nm, "_ack_latency"}, 64'(k), 64'd0);
    @(posedge ap_clk); #1;
    bus.reg_req = 1'b0; bus.reg_write_en = 1'b0;
  endtask

  task automatic rd(input logic [5:0] a, input logic [31:0] e, input string nm);
    reg_acc(1'b0, a, 32'd0, 4'h0, e, nm);
  endtask

  task automatic wr(input logic [5:0] a, input logic [31:0] d, input string nm);
    reg_acc(1'b1, a, d, 4'hF, 32'd0, nm);
  endtask

  task automatic run(input int n, input string nm);
    int start;
    @(posedge ap_clk); #1;
    start = run_cyc;
    go_0r = 1'b1;
    repeat (n) @(posedge ap_clk);
    #1 done_0r = 1'b1;
    @(posedge ap_clk); #1;
    go_0r = 1'b0; done_0r = 1'b0;
    chk({nm, "_running_cycles"}, 64'(run_cyc - start), 64'(n));
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.reg_req = 1'b0; bus.reg_write_en = 1'b0; bus.reg_addr = '0;
    bus.reg_wdata = '0; bus.reg_wstrb = '0;
    #1;
    chk("rst_ack", {63'd0, bus.reg_ack}, 64'd0);
    chk("rst_running", {63'd0, perf_running}, 64'd0);
    repeat (2) @(posedge ap_clk);
    #1 ap_rst_n = 1'b1;

    rd(6'h00, 32'h0, "rst_ctrl");
    rd(6'h04, 32'h0, "rst_runcnt");

    // First run: 100 cycles
    wr(6'h00, 32'h1, "wr_en");
    rd(6'h00, 32'h1, "ctrl_en");
    run(100, "run100");
    rd(6'h08, 32'd100, "last_lo_100");
    rd(6'h0C, 32'd0,   "last_hi_100");
    rd(6'h10, 32'd100, "total_lo_100");
    rd(6'h04, 32'd1,   "runcnt_1");

    // Second run: 50 cycles
    run(50, "run50");
    rd(6'h10, 32'd150, "total_lo_150");
    rd(6'h09, 32'd50,  "last_lo_50_low_addr_bits");
    rd(6'h04, 32'd2,   "runcnt_2");
    rd(6'h18, MAX_EXP, "max_lo");
    rd(6'h1C, 32'd0,   "max_hi");
    rd(6'h20, 32'd0,   "unmapped");
    wr(6'h04, 32'hFFFF, "wr_ro");
    rd(6'h04, 32'd2,   "runcnt_after_ro_wr");
    reg_acc(1'b1, 6'h00, 32'h0, 4'hE, 32'd0, "wr_no_strb0");
    rd(6'h00, 32'h1,   "ctrl_after_nostrb");

    // Abort mid-run, then done/go rises while disabled
    @(posedge ap_clk); #1 go_0r = 1'b1;
    repeat (5) @(posedge ap_clk);
    rd(6'h00, 32'h5, "ctrl_running");
    wr(6'h00, 32'h0, "wr_abort");
    chk("abort_running", {63'd0, perf_running}, 64'd0);
    @(posedge ap_clk); #1 done_0r = 1'b1;
    @(posedge ap_clk); #1 go_0r = 1'b0; done_0r = 1'b0;
    @(posedge ap_clk); #1 go_0r = 1'b1;
    @(posedge ap_clk); #1;
    chk("go_while_disabled", {63'd0, perf_running}, 64'd0);
    go_0r = 1'b0;
    rd(6'h04, 32'd2,   "runcnt_after_abort");
    rd(6'h08, 32'd50,  "last_after_abort");
    rd(6'h10, 32'd150, "total_after_abort");
    rd(6'h00, 32'h0,   "ctrl_after_abort");

    // TOTAL saturation
    wr(6'h00, 32'h1, "wr_en2");
    @(negedge ap_clk);
    dut.total_q = 48'hFFFF_FFFF_FFFA;
    run(10, "run10");
    rd(6'h00, 32'h9,          "ctrl_ovf");
    rd(6'h10, 32'hFFFF_FFFF,  "total_lo_sat");
    rd(6'h14, 32'h0000_FFFF,  "total_hi_sat");
    rd(6'h04, 32'd3,          "runcnt_3");
    rd(6'h08, 32'd10,         "last_lo_10");
    rd(6'h0C, 32'd0,          "last_hi_10");

    // Go and done rise together in IDLE: run starts, done ignored
    @(posedge ap_clk); #1 go_0r = 1'b1; done_0r = 1'b1;
    @(posedge ap_clk); #1;
    chk("go_done_same_enter", {63'd0, perf_running}, 64'd1);
    go_0r = 1'b0; done_0r = 1'b0;
    @(posedge ap_clk);
    @(posedge ap_clk); #1 done_0r = 1'b1;
    @(posedge ap_clk); #1 done_0r = 1'b0;
    rd(6'h08, 32'd3, "last_lo_3");
    rd(6'h04, 32'd4, "runcnt_4");

    // CLR lands in the same cycle as a done rise
    @(posedge ap_clk); #1 go_0r = 1'b1;
    repeat (4) @(posedge ap_clk);
    #1;
    exp_q.push_back(32'd0); name_q.push_back("wr_clr");
    bus.reg_req = 1'b1; bus.reg_write_en = 1'b1; bus.reg_addr = 6'h00;
    bus.reg_wdata = 32'h3; bus.reg_wstrb = 4'hF;
    @(posedge ap_clk); #1 done_0r = 1'b1;
    @(posedge ap_clk); #1;
    bus.reg_req = 1'b0; bus.reg_write_en = 1'b0;
    go_0r = 1'b0; done_0r = 1'b0;
    chk("clr_running", {63'd0, perf_running}, 64'd0);
    rd(6'h00, 32'h1, "ctrl_after_clr");
    rd(6'h14, 32'h0, "total_hi_shadow_clr");
    rd(6'h10, 32'h0, "total_lo_clr");
    rd(6'h04, 32'h0, "runcnt_clr");
    rd(6'h08, 32'h0, "last_clr");
    rd(6'h18, 32'h0, "max_clr");

    // Asynchronous reset mid-run
    @(posedge ap_clk); #1 go_0r = 1'b1;
    repeat (3) @(posedge ap_clk);
    #3 ap_rst_n = 1'b0;
    #1;
    chk("arst_running", {63'd0, perf_running}, 64'd0);
    chk("arst_ack", {63'd0, bus.reg_ack}, 64'd0);
    chk("arst_rdata", {32'd0, bus.reg_rdata}, 64'd0);
    go_0r = 1'b0;
    @(posedge ap_clk); #1 ap_rst_n = 1'b1;
    rd(6'h00, 32'h0, "ctrl_after_arst");
    rd(6'h04, 32'h0, "runcnt_after_arst");

    repeat (3) @(posedge ap_clk);
    chk("scoreboard_drained", 64'(exp_q.size()), 64'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
